// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO with per-pin direction, set/clear/toggle,
// input synchroniser and rise/fall edge interrupts with W1C pending bits.
module gpio_port #(
    parameter logic [15:0] BASE_ADDR   = 16'h0430,
    parameter int          WIDTH       = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [15:0]      i_addr,
    input  logic [15:0]      i_data,
    output logic [15:0]      o_data,
    input  logic [WIDTH-1:0] i_gp,
    output logic [WIDTH-1:0] o_gp,
    output logic [WIDTH-1:0] o_oe,
    output logic             o_irq
);

    localparam logic [2:0] R_DATA = 3'd0;
    localparam logic [2:0] R_TOG  = 3'd1;
    localparam logic [2:0] R_SET  = 3'd2;
    localparam logic [2:0] R_CLR  = 3'd3;
    localparam logic [2:0] R_DIR  = 3'd4;
    localparam logic [2:0] R_RISE = 3'd5;
    localparam logic [2:0] R_FALL = 3'd6;
    localparam logic [2:0] R_PEND = 3'd7;

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        COUNT,
        ARMED
    } arm_e;

    logic [15:0]      offset;
    logic             hit;
    logic [2:0]       sel;
    logic [WIDTH-1:0] wdata;
    logic             wr;
    logic             unused_data;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] gp_q, gp_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edges;
    logic [15:0]      data_q, data_d;
    logic [15:0]      rd_val;
    logic             irq_q;

    arm_e             state_q;
    logic [CW-1:0]    cnt_q;

    // Addresses below the base wrap to a large offset, so one compare
    // on the upper offset bits decodes the whole 8-register window.
    assign offset      = i_addr - BASE_ADDR;
    assign hit         = (offset[15:3] == 13'd0);
    assign sel         = offset[2:0];
    assign wdata       = i_data[WIDTH-1:0];
    assign wr          = i_we & hit;
    assign unused_data = ^i_data;
    assign sync        = sync_q[SYNC_STAGES-1];

    assign o_gp   = gp_q;
    assign o_oe   = oe_q;
    assign o_data = data_q;
    assign o_irq  = irq_q;

    // Input synchroniser chain and previous-sample register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= i_gp;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync;
        end
    end

    // Arm counter: hold off edge detection until the chain has settled.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= COUNT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                COUNT: begin
                    if (cnt_q == CNT_MAX) begin
                        state_q <= ARMED;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ARMED: state_q <= ARMED;
                default: state_q <= COUNT;
            endcase
        end
    end

    // Bus write decode and pending-bit next state.
    always_comb begin
        gp_d      = gp_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr) begin
            case (sel)
                R_DATA:  gp_d      = wdata;
                R_TOG:   gp_d      = gp_q ^ wdata;
                R_SET:   gp_d      = gp_q | wdata;
                R_CLR:   gp_d      = gp_q & ~wdata;
                R_DIR:   oe_d      = wdata;
                R_RISE:  rise_en_d = wdata;
                R_FALL:  fall_en_d = wdata;
                R_PEND:  clr       = wdata;
                default: clr       = '0;
            endcase
        end
        edges = '0;
        if (state_q == ARMED) begin
            edges = (sync & ~prev_q & rise_en_q)
                  | (~sync & prev_q & fall_en_q);
        end
        pend_d = (pend_q & ~clr) | edges;
    end

    // Read mux and registered read data.
    always_comb begin
        rd_val = '0;
        case (sel)
            R_DATA:  rd_val[WIDTH-1:0] = sync;
            R_TOG:   rd_val[WIDTH-1:0] = gp_q;
            R_SET:   rd_val[WIDTH-1:0] = gp_q;
            R_CLR:   rd_val[WIDTH-1:0] = gp_q;
            R_DIR:   rd_val[WIDTH-1:0] = oe_q;
            R_RISE:  rd_val[WIDTH-1:0] = rise_en_q;
            R_FALL:  rd_val[WIDTH-1:0] = fall_en_q;
            R_PEND:  rd_val[WIDTH-1:0] = pend_q;
            default: rd_val = '0;
        endcase
        if (!hit) begin
            data_d = '0;
        end else if (i_we) begin
            data_d = data_q;
        end else begin
            data_d = rd_val;
        end
    end

    // Architectural registers and interrupt output.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            gp_q      <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            data_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            gp_q      <= gp_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            irq_q     <= |pend_q;
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed vectors for gpio_port at default parameters
// plus an 8-bit instance at a different base address.
module tb_gpio_port;

    localparam logic [15:0] A_DATA = 16'h0430;
    localparam logic [15:0] A_TOG  = 16'h0431;
    localparam logic [15:0] A_SET  = 16'h0432;
    localparam logic [15:0] A_CLR  = 16'h0433;
    localparam logic [15:0] A_DIR  = 16'h0434;
    localparam logic [15:0] A_RISE = 16'h0435;
    localparam logic [15:0] A_FALL = 16'h0436;
    localparam logic [15:0] A_PEND = 16'h0437;

    logic        clk;
    logic        rst;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] rdata;
    logic [15:0] gp;
    logic [15:0] o_gp;
    logic [15:0] o_oe;
    logic        irq;

    logic        we8;
    logic [15:0] addr8;
    logic [15:0] data8;
    logic [15:0] rdata8;
    logic [7:0]  gp8;
    logic [7:0]  o_gp8;
    logic [7:0]  o_oe8;
    logic        irq8;

    logic [15:0] v;
    int          n_vec;
    int          n_bad;

    gpio_port u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (we),
        .i_addr (addr),
        .i_data (data),
        .o_data (rdata),
        .i_gp   (gp),
        .o_gp   (o_gp),
        .o_oe   (o_oe),
        .o_irq  (irq)
    );

    gpio_port #(
        .BASE_ADDR   (16'h0500),
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) u_dut8 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (we8),
        .i_addr (addr8),
        .i_data (data8),
        .o_data (rdata8),
        .i_gp   (gp8),
        .o_gp   (o_gp8),
        .o_oe   (o_oe8),
        .o_irq  (irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        we   = 1'b1;
        addr = a;
        data = d;
        tick();
        we   = 1'b0;
        addr = 16'h0000;
        data = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] q);
        we   = 1'b0;
        addr = a;
        tick();
        q    = rdata;
        addr = 16'h0000;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        we    = 1'b0;
        addr  = 16'h0000;
        data  = 16'h0000;
        gp    = 16'hFFFF;
        we8   = 1'b0;
        addr8 = 16'h0000;
        data8 = 16'h0000;
        gp8   = 8'h00;

        // reset with all pins high
        repeat (3) tick();
        chk("rst_gp", o_gp, 16'h0000);
        chk("rst_oe", o_oe, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        chk("rst_data", rdata, 16'h0000);

        // enable rise on the release edge: arm counter must hide the
        // apparent 0->1 of the already-high pins
        rst = 1'b1;
        wr(A_RISE, 16'hFFFF);
        repeat (6) tick();
        chk("arm_irq", {15'b0, irq}, 16'h0000);
        rd(A_PEND, v);
        chk("arm_pend", v, 16'h0000);
        rd(A_DATA, v);
        chk("sync_in", v, 16'hFFFF);
        wr(A_RISE, 16'h0000);

        // output ops
        wr(A_DATA, 16'h00F0);
        chk("out_data", o_gp, 16'h00F0);
        wr(A_SET, 16'h000F);
        chk("out_set", o_gp, 16'h00FF);
        wr(A_CLR, 16'h0030);
        chk("out_clr", o_gp, 16'h00CF);
        wr(A_TOG, 16'hFF00);
        chk("out_tog", o_gp, 16'hFFCF);
        rd(A_TOG, v);
        chk("rd_tog", v, 16'hFFCF);
        wr(A_SET, 16'h0000);
        chk("wr_hold", rdata, 16'hFFCF);
        wr(16'h0438, 16'hFFFF);
        chk("oow_wr", o_gp, 16'hFFCF);
        wr(A_DIR, 16'h5A5A);
        chk("dir", o_oe, 16'h5A5A);
        rd(A_DIR, v);
        chk("rd_dir", v, 16'h5A5A);
        rd(16'h0438, v);
        chk("oow_hi", v, 16'h0000);
        rd(A_DIR, v);
        rd(16'h042F, v);
        chk("oow_lo", v, 16'h0000);

        // edge interrupts
        gp = 16'h0002;
        repeat (4) tick();
        wr(A_RISE, 16'h0001);
        wr(A_FALL, 16'h0002);
        rd(A_PEND, v);
        chk("pend0", v, 16'h0000);
        gp   = 16'h0003;
        addr = A_PEND;
        tick();
        tick();
        tick();
        chk("rise_lat_pend", rdata, 16'h0000);
        chk("rise_lat_irq", {15'b0, irq}, 16'h0000);
        tick();
        chk("rise_pend", rdata, 16'h0001);
        chk("rise_irq", {15'b0, irq}, 16'h0001);
        addr = 16'h0000;
        gp = 16'h0001;
        repeat (4) tick();
        rd(A_PEND, v);
        chk("fall_pend", v, 16'h0003);
        wr(A_PEND, 16'h0001);
        rd(A_PEND, v);
        chk("w1c", v, 16'h0002);
        wr(A_PEND, 16'h0002);
        chk("irq_lag", {15'b0, irq}, 16'h0001);
        tick();
        chk("irq_drop", {15'b0, irq}, 16'h0000);

        // set beats clear
        gp = 16'h0000;
        repeat (4) tick();
        gp = 16'h0001;
        tick();
        tick();
        wr(A_PEND, 16'h0001);
        rd(A_PEND, v);
        chk("set_win", v, 16'h0001);
        wr(A_RISE, 16'h0000);
        rd(A_PEND, v);
        chk("en_keep", v, 16'h0001);
        chk("en_keep_irq", {15'b0, irq}, 16'h0001);

        // 8-bit instance
        we8   = 1'b1;
        addr8 = 16'h0500;
        data8 = 16'hABCD;
        gp8   = 8'hCD;
        tick();
        we8   = 1'b0;
        chk("w8_gp", {8'h00, o_gp8}, 16'h00CD);
        addr8 = 16'h0501;
        tick();
        chk("w8_tog", rdata8, 16'h00CD);
        repeat (2) tick();
        addr8 = 16'h0500;
        tick();
        chk("w8_din", rdata8, 16'h00CD);
        addr8 = 16'h0508;
        tick();
        chk("w8_oow", rdata8, 16'h0000);
        addr8 = 16'h0000;

        // reset mid-run
        wr(A_DATA, 16'h1234);
        chk("pre_gp", o_gp, 16'h1234);
        gp = 16'hFFFF;
        rd(A_PEND, v);
        chk("pre_pend", v, 16'h0001);
        rst  = 1'b0;
        we   = 1'b1;
        addr = A_DATA;
        data = 16'hFFFF;
        tick();
        we   = 1'b0;
        addr = 16'h0000;
        rst  = 1'b1;
        chk("mr_gp", o_gp, 16'h0000);
        chk("mr_oe", o_oe, 16'h0000);
        chk("mr_irq", {15'b0, irq}, 16'h0000);
        chk("mr_data", rdata, 16'h0000);
        chk("mr_gp8", {8'h00, o_gp8}, 16'h0000);
        wr(A_RISE, 16'hFFFF);
        repeat (6) tick();
        rd(A_PEND, v);
        chk("mr_arm", v, 16'h0000);
        chk("mr_arm_irq", {15'b0, irq}, 16'h0000);
        rd(A_RISE, v);
        chk("mr_rise", v, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised memory-mapped GPIO port, successor to the fixed 16-bit GPIO. It adds configurable width, per-pin direction, set/clear/toggle writes, an input synchroniser, and per-pin rising/falling-edge interrupts with a write-1-to-clear pending register. It sits on the 16-bit peripheral bus beside the other memory-mapped peripherals and drives one interrupt line to the CPU.

## Interface
- BASE_ADDR, 16'h0430: address of register 0; the block decodes BASE_ADDR..BASE_ADDR+7.
- WIDTH, 16: pin count, legal range 1..16.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..3.
- i_clk  in  1  clock; reset i_rst, synchronous, active-low; clock i_clk.
- i_rst  in  1  synchronous active-low reset.
- i_we  in  1  write strobe for the current i_addr.
- i_addr  in  16  bus address.
- i_data  in  16  write data; bits [15:WIDTH] are ignored.
- o_data  out  16  registered read data, zero-extended above WIDTH.
- i_gp  in  WIDTH  asynchronous input pins.
- o_gp  out  WIDTH  output data register.
- o_oe  out  WIDTH  per-pin output enable (1 = drive).
- o_irq  out  1  registered interrupt: OR of all pending bits.

## Operation
Register map, as offsets from BASE_ADDR. "Write" means the update applied when i_we=1; "read" means the value captured when i_we=0.
- +0 DATA: write sets o_gp = i_data. Read returns the synchronised inputs.
- +1 TOGGLE: write sets o_gp ^= i_data. Read returns o_gp.
- +2 SET: write sets o_gp |= i_data. Read returns o_gp.
- +3 CLR: write sets o_gp &= ~i_data. Read returns o_gp.
- +4 DIR: write sets o_oe = i_data. Read returns o_oe.
- +5 RISE_EN: rising-edge interrupt enable per pin, read/write.
- +6 FALL_EN: falling-edge interrupt enable per pin, read/write.
- +7 PEND: read returns pending bits. Write clears every bit where i_data is 1 (write-1-to-clear).

Bus rules:
- On a write cycle o_data is held.
- Any address outside the window gives o_data <= 0 on that edge, whether read or write.

Synchroniser and edge detection:
- i_gp passes through SYNC_STAGES flops to produce sync.
- A prev register holds sync from the previous cycle.
- rise = sync & ~prev & RISE_EN.
- fall = ~sync & prev & FALL_EN.
- Edges are detected on every pin regardless of direction, so an output pin looped back still raises interrupts.
- Pending update: pend <= (pend & ~clr_mask) | rise | fall. A set in the same cycle as a clear wins.
- Changing RISE_EN or FALL_EN never clears pending bits.

Arm counter:
- After reset release, a counter suppresses edge detection for SYNC_STAGES+1 cycles.
- This keeps pins already high at reset from generating false rising edges.
- Counter states are COUNT followed by ARMED. The counter saturates at ARMED and re-enters COUNT only on reset.

Reset (i_rst=0 at a clock edge), applied every cycle i_rst is low, including mid-operation:
- o_gp, o_oe, o_data, RISE_EN, FALL_EN, PEND, o_irq, the synchroniser flops and prev all go to 0.
- The arm counter goes to 0.
- Bus writes are ignored while in reset.

## Timing
- Read latency: o_data is valid on the edge after the address is presented, i.e. 1 cycle.
- Write effect: the register updates on the edge where i_we=1. o_gp, o_oe and enables are visible to the next cycle's logic and reads.
- Input to DATA read: SYNC_STAGES edges to reach sync, plus 1 edge to o_data.
- Input to PEND: SYNC_STAGES edges to sync, plus 1 edge to set PEND (sync vs prev compare). o_irq follows 1 edge later.
- PEND clear to o_irq: the bit clears on the write edge. o_irq drops 1 edge later if no other bit is pending.
- Back-to-back accesses are supported every cycle with no stall and no ready signal.

## Test plan
- Reset: hold i_rst=0 with i_gp=16'hFFFF and release. Then: o_gp=0, o_oe=0, o_irq=0, PEND=0 with no spurious edge; DATA read returns 16'hFFFF after sync latency.
- Output ops: write DATA=16'h00F0, SET 16'h000F, CLR 16'h0030, TOGGLE 16'hFF00. Then o_gp is 16'h00FF, 16'h00CF, 16'hFFCF after each step; TOGGLE read returns 16'hFFCF.
- Edge IRQ: RISE_EN=16'h0001, FALL_EN=16'h0002; drive i_gp[0] 0→1, then i_gp[1] 1→0. Then PEND=16'h0003 and o_irq=1 at the specified latency; a PEND write 16'h0001 leaves 16'h0002.
- Set beats clear: a rising edge on bit 0 reaches the PEND update in the same cycle as a PEND write 16'h0001. Then bit 0 stays set.
- WIDTH=8, BASE_ADDR=16'h0500: write DATA=16'hABCD. Then o_gp=8'hCD, read returns 16'h00CD; reading 16'h0508 returns 0.
- Reset mid-run: with PEND nonzero and o_gp=16'h1234, pulse i_rst=0 for one cycle. Then all registers and o_irq are 0 and the arm counter restarts.
